// File: rtl/inv_round_counter.sv
// Decryption round sequencer: counts rounds down from NUM_ROUNDS to 0,
// selects the round key and drives the inverse-datapath step enables.
// The finished block is handed downstream with a valid/ready handshake.
//
// Ports:
//   clk, n_rst        clock (rising edge), asynchronous active-low reset
//   start             request to decrypt one block (IDLE, or DONE with out_ready)
//   key_ready         round key for round_idx available; gates every step
//   abort             synchronous cancel back to IDLE, highest priority
//   out_ready         downstream accepts the result
//   round_idx         current round / round-key select
//   load_state        INIT step: load ciphertext into the state register
//   inv_sub_shift_en  apply InvShiftRows + InvSubBytes this step
//   add_key_en        apply AddRoundKey this step
//   inv_mix_en        apply InvMixColumns this step
//   busy              high in INIT, ROUND, FINAL
//   done_valid        result valid, held until accepted
module inv_round_counter #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               key_ready,
  input  logic               abort,
  input  logic               out_ready,
  output logic [ROUND_W-1:0] round_idx,
  output logic               load_state,
  output logic               inv_sub_shift_en,
  output logic               add_key_en,
  output logic               inv_mix_en,
  output logic               busy,
  output logic               done_valid
);

  localparam logic [ROUND_W-1:0] RoundLast  = ROUND_W'(NUM_ROUNDS);
  localparam logic [ROUND_W-1:0] RoundFirst = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] RoundOne   = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] RoundZero  = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               compute_c;
  logic               step_c;

  // State and round index registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      round_q <= RoundZero;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state and round index; abort overrides everything
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort) begin
      state_d = ST_IDLE;
      round_d = RoundZero;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_INIT;
            round_d = RoundLast;
          end
        end
        ST_INIT: begin
          if (key_ready) begin
            state_d = ST_ROUND;
            round_d = RoundFirst;
          end
        end
        ST_ROUND: begin
          if (key_ready) begin
            if (round_q == RoundOne) begin
              state_d = ST_FINAL;
              round_d = RoundZero;
            end else begin
              round_d = round_q - RoundOne;
            end
          end
        end
        ST_FINAL: begin
          if (key_ready) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (start) begin
              state_d = ST_INIT;
              round_d = RoundLast;
            end else begin
              state_d = ST_IDLE;
              round_d = RoundZero;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = RoundZero;
        end
      endcase
    end
  end

  // Output decode; enables are suppressed on stall and in the abort cycle
  always_comb begin
    compute_c        = (state_q == ST_INIT) || (state_q == ST_ROUND) ||
                       (state_q == ST_FINAL);
    step_c           = key_ready && !abort && compute_c;
    round_idx        = round_q;
    load_state       = step_c && (state_q == ST_INIT);
    inv_sub_shift_en = step_c && ((state_q == ST_ROUND) || (state_q == ST_FINAL));
    add_key_en       = step_c;
    inv_mix_en       = step_c && (state_q == ST_ROUND);
    busy             = compute_c;
    done_valid       = (state_q == ST_DONE);
  end

endmodule
